decode_issue: RTL and testbench
===============================

Name: decode_issue

Overview:
- Decode/issue stage sitting directly upstream of the integer register file (regf) and directly upstream of execute.
- Accepts fetched instructions over a valid/ready handshake and extracts RV32I fields and immediates.
- Drives regf read addresses and read enable so operands arrive one cycle later, aligned with this block's registered outputs.
- Holds a 32-entry pending-write scoreboard and stalls RAW/WAW hazards against in-flight multi-cycle producers.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
NREG, 32, number of architectural registers; scoreboard depth.

Ports:
clk  in  1  clock
rstn  in  1  reset
in_valid  in  1  fetch offers an instruction
in_ready  out  1  stage accepts this cycle
in_pc  in  32  PC of offered instruction
in_instr  in  32  instruction word
rs1  out  5  regf read address 1 = in_instr[19:15]
rs2  out  5  regf read address 2 = in_instr[24:20]
r_enabled  out  1  regf read strobe; equals accept (in_valid && in_ready)
out_valid  out  1  decoded instruction valid
out_ready  in  1  execute consumes this cycle
out_pc  out  32  PC
out_rd  out  5  destination register
out_opcode  out  7  instr[6:0]
out_funct3  out  3  instr[14:12]
out_funct7  out  7  instr[31:25]
out_imm  out  32  sign-extended immediate
out_writes_rd  out  1  instruction writes rd (rd != 0)
out_illegal  out  1  unknown opcode
wb_valid  in  1  writeback retiring a write
wb_addr  in  5  register being written back
flush  in  1  kill the decoded instruction (branch redirect)

Behaviour:
- Reset: rstn, synchronous, active-low; clock clk. While rstn=0 at a clk edge: out_valid=0, all out_* fields=0, scoreboard=0. in_ready=0 and r_enabled=0 combinationally while rstn=0.
- Accept: fire = in_valid && in_ready. On fire, all out_* fields are registered from the decode of in_instr and out_valid=1 on the next edge. Latency is 1 cycle, the same as the regf read, so regf operands pair with out_* while out_valid.
- Hold: if out_valid && !out_ready, out_* stay stable. r_enabled=0 in this case, so regf outputs also hold.
- If out_ready with no fire: out_valid clears next edge.
- in_ready = rstn && !flush && !(out_valid && !out_ready) && !hazard.
- Uses: rs1 is used by all opcodes except LUI, AUIPC, JAL. rs2 is used by BRANCH, STORE and OP.
- writes_rd: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP write rd, and only when rd != 0.
- Hazard: set if any used source register (nonzero) has its scoreboard bit set, or if writes_rd and the rd bit is set (WAW). A source whose bit is set but matches wb_addr while wb_valid is NOT a hazard, because regf forwards same-cycle write data. The rd WAW check honours the same wb exemption.
- Scoreboard set: on fire with writes_rd, bit[rd] sets.
- Scoreboard clear: wb_valid clears bit[wb_addr]. If set and clear hit the same address in the same cycle, set wins. Bit 0 is never set.
- Flush: out_valid=0 next edge. If out_valid && out_writes_rd && !out_ready, bit[out_rd] clears. No fire occurs in a flush cycle. The WAW stall guarantees at most one outstanding writer per register, so clearing on flush is exact.
- Immediates (all sign-extended from instr[31]):
  - I-type (JALR, LOAD, OP-IMM): instr[31:20].
  - S-type: {instr[31:25], instr[11:7]}.
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U-type: {instr[31:12], 12'b0}.
  - J-type: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All others: 0.
- Legal opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011.
- Any other opcode: out_illegal=1, writes_rd=0, no scoreboard set. The instruction still issues so execute can trap.
- Reset mid-stall: all state clears, and the pending handshake is dropped.

Test Plan:
- Reset with rstn=0 for 2 cycles with in_valid=1 -> in_ready=0, r_enabled=0, out_valid=0, scoreboard empty.
- addi x5,x0,-1 (0xFFF00293), out_ready=1 -> next cycle out_valid=1, out_rd=5, out_imm=0xFFFFFFFF, out_writes_rd=1, rs1=0 driven in the fire cycle. Scoreboard bit5 is set.
- With bit5 pending, offer add x6,x5,x1 -> in_ready=0 and r_enabled=0 until wb_valid=1, wb_addr=5. It fires in that same wb cycle.
- jal x1,+2048 (0x001000EF) -> out_imm=0x00000800. Then beq x1,x2,-4 (0xFE208EE3) stalls on bit1; after clear, out_imm=0xFFFFFFFC.
- out_ready=0 for 3 cycles after issue -> out_* and regf operands stable, in_ready=0. Then flush=1 -> out_valid=0 and bit[out_rd] cleared.
- Opcode 0x0000007F -> out_illegal=1, out_writes_rd=0, scoreboard unchanged. wb_valid with wb_addr=0 has no effect.

Source files
------------

// File: rtl/decode_issue.sv
// Decode/issue stage: RV32I field/immediate extraction, regf read strobe, 32-entry pending-write scoreboard.
// Latency: 1 cycle from accept to out_valid, aligned with the regf read data.
// Backpressure: holds outputs while out_valid && !out_ready; stalls intake on RAW/WAW hazards or flush.
module decode_issue #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic            r_enabled,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic            out_writes_rd,
  output logic            out_illegal,
  input  logic            wb_valid,
  input  logic [4:0]      wb_addr,
  input  logic            flush
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [NREG-1:0] sb;
  logic [NREG-1:0] sb_next;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [31:0]     imm;
  logic            rd_class;
  logic            illegal;
  logic            uses_rs1;
  logic            uses_rs2;
  logic            writes_rd;
  logic            hazard;
  logic            fire;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];

  // A register is busy unless its writeback lands this very cycle (regf forwards it).
  function automatic logic busy(input logic [NREG-1:0] bits, input logic [4:0] a,
                                input logic wv, input logic [4:0] wa);
    return bits[a] && !(wv && (wa == a));
  endfunction

  // Opcode classification and immediate selection.
  always_comb begin
    imm      = 32'h0;
    rd_class = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        imm      = {in_instr[31:12], 12'h000};
        rd_class = 1'b1;
      end
      OP_JAL: begin
        imm      = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
        rd_class = 1'b1;
      end
      OP_JALR, OP_LOAD, OP_IMM: begin
        imm      = {{20{in_instr[31]}}, in_instr[31:20]};
        rd_class = 1'b1;
      end
      OP_STORE:  imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      OP_BRANCH: imm = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      OP_OP:     rd_class = 1'b1;
      OP_FENCE, OP_SYSTEM: rd_class = 1'b0;
      default:   illegal = 1'b1;
    endcase
  end

  assign uses_rs1  = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
  assign uses_rs2  = (opcode == OP_BRANCH) || (opcode == OP_STORE) || (opcode == OP_OP);
  assign writes_rd = rd_class && (rd != 5'd0);

  // RAW on either used source, WAW on the destination.
  always_comb begin
    hazard = 1'b0;
    if (uses_rs1 && (rs1 != 5'd0) && busy(sb, rs1, wb_valid, wb_addr)) hazard = 1'b1;
    if (uses_rs2 && (rs2 != 5'd0) && busy(sb, rs2, wb_valid, wb_addr)) hazard = 1'b1;
    if (writes_rd && busy(sb, rd, wb_valid, wb_addr))                  hazard = 1'b1;
  end

  assign in_ready  = rstn && !flush && !(out_valid && !out_ready) && !hazard;
  assign fire      = in_valid && in_ready;
  assign r_enabled = fire;

  // Scoreboard update: clears first, so a same-cycle set on the same address wins.
  always_comb begin
    sb_next = sb;
    if (wb_valid) sb_next[wb_addr] = 1'b0;
    if (flush && out_valid && out_writes_rd && !out_ready) sb_next[out_rd] = 1'b0;
    if (fire && writes_rd) sb_next[rd] = 1'b1;
    sb_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (!rstn) sb <= '0;
    else       sb <= sb_next;
  end

  // Output register: load on accept, drain on consume or flush, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_rd        <= '0;
      out_opcode    <= '0;
      out_funct3    <= '0;
      out_funct7    <= '0;
      out_imm       <= '0;
      out_writes_rd <= 1'b0;
      out_illegal   <= 1'b0;
    end else if (fire) begin
      out_valid     <= 1'b1;
      out_pc        <= in_pc;
      out_rd        <= rd;
      out_opcode    <= opcode;
      out_funct3    <= in_instr[14:12];
      out_funct7    <= in_instr[31:25];
      out_imm       <= imm;
      out_writes_rd <= writes_rd;
      out_illegal   <= illegal;
    end else if (flush || out_ready) begin
      out_valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: scenario tasks with inline checks plus a scoreboard queue
// that predicts each issued instruction at accept and compares it when execute consumes it.
// Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
module tb_decode_issue;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        wr;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = 32'h0;
  logic [31:0] in_instr = 32'h0;
  logic [4:0]  rs1, rs2;
  logic        r_enabled;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [4:0]  out_rd;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [31:0] out_imm;
  logic        out_writes_rd;
  logic        out_illegal;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic        flush = 1'b0;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];

  decode_issue #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .rs1(rs1), .rs2(rs2), .r_enabled(r_enabled),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_imm(out_imm), .out_writes_rd(out_writes_rd), .out_illegal(out_illegal),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush)
  );

  always #5 clk = ~clk;

  // Reference decode of one instruction.
  function automatic exp_t model(input logic [31:0] pc, input logic [31:0] ins);
    exp_t e;
    logic wop;
    e.pc = pc; e.rd = ins[11:7]; e.opcode = ins[6:0];
    e.f3 = ins[14:12]; e.f7 = ins[31:25]; e.imm = 32'h0; e.ill = 1'b0; wop = 1'b0;
    case (ins[6:0])
      7'h37, 7'h17: begin e.imm = {ins[31:12], 12'h0}; wop = 1'b1; end
      7'h6F: begin e.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; wop = 1'b1; end
      7'h67, 7'h03, 7'h13: begin e.imm = {{20{ins[31]}}, ins[31:20]}; wop = 1'b1; end
      7'h23: e.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      7'h63: e.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      7'h33: wop = 1'b1;
      7'h0F, 7'h73: wop = 1'b0;
      default: e.ill = 1'b1;
    endcase
    e.wr = wop && (ins[11:7] != 5'd0);
    return e;
  endfunction

  // Monitor: pop/compare on consume, discard on flush-kill, push on accept.
  always @(negedge clk) begin
    exp_t e, got;
    if (!rstn) begin
      q.delete();
    end else begin
      if (out_valid && (out_ready || flush)) begin
        if (q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL sb_underflow: output pc=%h with no pending expectation", out_pc);
        end else begin
          e = q.pop_front();
          if (out_ready) begin
            got.pc = out_pc; got.rd = out_rd; got.opcode = out_opcode; got.f3 = out_funct3;
            got.f7 = out_funct7; got.imm = out_imm; got.wr = out_writes_rd; got.ill = out_illegal;
            n_vec++;
            if (got !== e) begin
              n_err++;
              $display("FAIL sb_issue: got pc=%h rd=%0d op=%h f3=%h f7=%h imm=%h wr=%b ill=%b, want pc=%h rd=%0d op=%h f3=%h f7=%h imm=%h wr=%b ill=%b",
                       got.pc, got.rd, got.opcode, got.f3, got.f7, got.imm, got.wr, got.ill,
                       e.pc, e.rd, e.opcode, e.f3, e.f7, e.imm, e.wr, e.ill);
            end
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_pc, in_instr));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic retire(input logic [4:0] a);
    tick(); wb_valid = 1'b1; wb_addr = a;
    tick(); wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b1; in_instr = 32'h00128333; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      n_vec++;
      if ({in_ready, r_enabled, out_valid} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_outputs: in_ready/r_enabled/out_valid=%b want 000", {in_ready, r_enabled, out_valid});
      end
    end
    tick(); rstn = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_addi();
    tick(); in_valid = 1'b1; in_instr = 32'hFFF00293; in_pc = 32'h100; out_ready = 1'b1; #1;
    n_vec++;
    if ({in_ready, r_enabled, rs1} !== {2'b11, 5'd0}) begin
      n_err++; $display("FAIL addi_fire: ready/ren/rs1=%b want 1100000", {in_ready, r_enabled, rs1});
    end
    tick(); in_valid = 1'b0; #1;
    n_vec++;
    if ({out_valid, out_rd, out_imm, out_writes_rd} !== {1'b1, 5'd5, 32'hFFFFFFFF, 1'b1}) begin
      n_err++; $display("FAIL addi_out: valid=%b rd=%0d imm=%h wr=%b want 1 5 ffffffff 1", out_valid, out_rd, out_imm, out_writes_rd);
    end
  endtask

  task automatic test_raw_stall();
    tick(); in_valid = 1'b1; in_instr = 32'h00128333; in_pc = 32'h104; #1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({in_ready, r_enabled} !== 2'b00) begin
        n_err++; $display("FAIL raw_stall: ready/ren=%b want 00 (cycle %0d)", {in_ready, r_enabled}, i);
      end
      tick(); #1;
    end
    wb_valid = 1'b1; wb_addr = 5'd5; #1;
    n_vec++;
    if ({in_ready, r_enabled, rs1, rs2} !== {2'b11, 5'd5, 5'd1}) begin
      n_err++; $display("FAIL raw_wb_fire: ready/ren=%b rs1=%0d rs2=%0d want 11 5 1", {in_ready, r_enabled}, rs1, rs2);
    end
    tick(); wb_valid = 1'b0; in_valid = 1'b0; #1;
    n_vec++;
    if ({out_valid, out_rd} !== {1'b1, 5'd6}) begin
      n_err++; $display("FAIL raw_out: valid=%b rd=%0d want 1 6", out_valid, out_rd);
    end
    retire(5'd6);
  endtask

  task automatic test_jal_beq();
    tick(); in_valid = 1'b1; in_instr = 32'h001000EF; in_pc = 32'h200; #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL jal_ready: in_ready=%b want 1", in_ready); end
    tick(); in_instr = 32'hFE208EE3; in_pc = 32'h204; #1;
    n_vec++;
    if ({out_imm, out_rd, in_ready} !== {32'h00000800, 5'd1, 1'b0}) begin
      n_err++; $display("FAIL jal_out: imm=%h rd=%0d in_ready=%b want 00000800 1 0", out_imm, out_rd, in_ready);
    end
    tick(); in_valid = 1'b0; wb_valid = 1'b1; wb_addr = 5'd1;
    tick(); wb_valid = 1'b0; in_valid = 1'b1; #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL beq_cleared: in_ready=%b want 1", in_ready); end
    tick(); in_valid = 1'b0; #1;
    n_vec++;
    if ({out_valid, out_imm, out_writes_rd} !== {1'b1, 32'hFFFFFFFC, 1'b0}) begin
      n_err++; $display("FAIL beq_out: valid=%b imm=%h wr=%b want 1 fffffffc 0", out_valid, out_imm, out_writes_rd);
    end
  endtask

  task automatic test_hold_flush();
    tick(); in_valid = 1'b1; in_instr = 32'h12345537; in_pc = 32'h300; out_ready = 1'b0; #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL lui_ready: in_ready=%b want 1", in_ready); end
    tick(); in_instr = 32'h00100593; in_pc = 32'h304;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if ({out_valid, out_rd, out_imm, out_pc, in_ready, r_enabled} !== {1'b1, 5'd10, 32'h12345000, 32'h300, 2'b00}) begin
        n_err++; $display("FAIL hold_stable: valid=%b rd=%0d imm=%h pc=%h ready/ren=%b want 1 10 12345000 300 00 (cycle %0d)",
                          out_valid, out_rd, out_imm, out_pc, {in_ready, r_enabled}, i);
      end
      tick();
    end
    flush = 1'b1; #1;
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready: in_ready=%b want 0", in_ready); end
    tick(); flush = 1'b0; in_instr = 32'h00150593; out_ready = 1'b1; #1;
    n_vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++; $display("FAIL flush_clear: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    tick(); in_valid = 1'b0; #1;
    n_vec++;
    if ({out_valid, out_rd} !== {1'b1, 5'd11}) begin
      n_err++; $display("FAIL flush_next: valid=%b rd=%0d want 1 11", out_valid, out_rd);
    end
    retire(5'd11);
  endtask

  task automatic test_illegal();
    tick(); in_valid = 1'b1; in_instr = 32'h0000007F; in_pc = 32'h400; out_ready = 1'b1;
    tick(); in_instr = 32'h00000FFF; in_pc = 32'h404; #1;
    n_vec++;
    if ({out_illegal, out_writes_rd} !== 2'b10) begin
      n_err++; $display("FAIL illegal_7f: ill=%b wr=%b want 1 0", out_illegal, out_writes_rd);
    end
    tick(); in_instr = 32'h000F8093; in_pc = 32'h408; wb_valid = 1'b1; wb_addr = 5'd0; #1;
    n_vec++;
    if ({out_illegal, out_writes_rd, out_rd, in_ready} !== {2'b10, 5'd31, 1'b1}) begin
      n_err++; $display("FAIL illegal_nosb: ill=%b wr=%b rd=%0d in_ready=%b want 1 0 31 1", out_illegal, out_writes_rd, out_rd, in_ready);
    end
    tick(); in_valid = 1'b0; wb_valid = 1'b0;
    retire(5'd1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] prog [4];
    prog[0] = 32'h0021A423; prog[1] = 32'h80000617; prog[2] = 32'hFF812683; prog[3] = 32'h00008067;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); in_valid = 1'b1; in_instr = prog[i]; in_pc = 32'h500 + 32'(i * 4); #1;
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: in_ready=%b want 1 (slot %0d)", in_ready, i); end
    end
    tick(); in_valid = 1'b0;
    retire(5'd12);
    retire(5'd13);
  endtask

  task automatic test_reset_mid_stall();
    tick(); in_valid = 1'b1; in_instr = 32'h00100293; in_pc = 32'h600; out_ready = 1'b0;
    tick(); in_instr = 32'h00128333; in_pc = 32'h604; #1;
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL midrst_stall: in_ready=%b want 0", in_ready); end
    tick(); rstn = 1'b0; #1;
    n_vec++;
    if ({in_ready, r_enabled} !== 2'b00) begin n_err++; $display("FAIL midrst_comb: ready/ren=%b want 00", {in_ready, r_enabled}); end
    tick(); rstn = 1'b1; #1;
    n_vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++; $display("FAIL midrst_clear: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    tick(); in_valid = 1'b0; out_ready = 1'b1; #1;
    n_vec++;
    if ({out_valid, out_rd} !== {1'b1, 5'd6}) begin
      n_err++; $display("FAIL midrst_issue: valid=%b rd=%0d want 1 6", out_valid, out_rd);
    end
    retire(5'd6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_addi();
    test_raw_stall();
    test_jal_beq();
    test_hold_flush();
    test_illegal();
    test_back_to_back();
    test_reset_mid_stall();
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    n_vec++;
    if (q.size() != 0) begin
      n_err++; $display("FAIL sb_drain: %0d expectations never issued, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
